// File: rtl/ddr3_dfi_pkg.sv
// ddr3_dfi_pkg: shared DFI command encodings, error codes and bank count
// Used by ddr3_dfi_responder and its testbench.
package ddr3_dfi_pkg;
  typedef enum logic [2:0] {
    CMD_MRS  = 3'b000,
    CMD_REF  = 3'b001,
    CMD_PRE  = 3'b010,
    CMD_ACT  = 3'b011,
    CMD_WR   = 3'b100,
    CMD_RD   = 3'b101,
    CMD_ZQCL = 3'b110,
    CMD_NOP  = 3'b111
  } cmd_e;
  localparam logic [2:0] ERR_NONE        = 3'd0;
  localparam logic [2:0] ERR_ACT_OPEN    = 3'd1;
  localparam logic [2:0] ERR_BANK_CLOSED = 3'd2;
  localparam logic [2:0] ERR_Q_FULL      = 3'd3;
  localparam logic [2:0] ERR_RD_EMPTY    = 3'd4;
  localparam logic [2:0] ERR_WR_EMPTY    = 3'd5;
  localparam logic [2:0] ERR_REF_OPEN    = 3'd6;
  localparam logic [2:0] ERR_UNSUP       = 3'd7;
  localparam int NUM_BANKS = 8;
endpackage

// File: rtl/dfi_addr_fifo.sv
// dfi_addr_fifo: small burst-address FIFO with full/empty flags
// Ports: clk_i, rst_ni (async active-low), push_i/data_i write side,
// pop_i/data_o read side (data_o shows the head), full_o, empty_o.
// The caller only pushes when not full (or when popping the same cycle)
// and only pops when not empty. DEPTH must be a power of 2.
module dfi_addr_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW:0]  wp_q, rp_q;
  assign empty_o = wp_q == rp_q;
  assign full_o  = (wp_q[PW] != rp_q[PW]) && (wp_q[PW-1:0] == rp_q[PW-1:0]);
  assign data_o  = mem_q[rp_q[PW-1:0]];
  always_ff @(posedge clk_i)
    if (push_i) mem_q[wp_q[PW-1:0]] <= data_i;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (push_i) wp_q <= wp_q + (PW+1)'(1);
      if (pop_i)  rp_q <= rp_q + (PW+1)'(1);
    end
endmodule

// File: rtl/ddr3_dfi_responder.sv
// ddr3_dfi_responder: DFI-side stand-in for a DDR3 PHY + SDRAM
// Decodes DFI commands, tracks rows per bank, stores WRITE bursts in block
// RAM and returns READ bursts RD_LATENCY clocks after each dfi_rden_i beat.
// Ports: clock, reset_n (async active-low); DFI command inputs dfi_cke_i,
// dfi_cs_ni, dfi_ras_ni/cas_ni/we_ni, dfi_bank_i, dfi_addr_i; write data
// dfi_wren_i/dfi_mask_i/dfi_data_i; read request dfi_rden_i; read return
// dfi_rvld_o/dfi_last_o/dfi_data_o; sticky err_o with first err_code_o.
// Define DDR3_DFI_RESP_CHECK_EN to compile in the bank-state checker
// (error codes 1, 2, 6, 7); otherwise only queue errors 3/4/5 exist.
module ddr3_dfi_responder
  import ddr3_dfi_pkg::*;
#(
  parameter int DDR_ROW_BITS  = 15,
  parameter int DDR_COL_BITS  = 10,
  parameter int DFI_DQ_WIDTH  = 32,
  parameter int DFI_DM_WIDTH  = 4,
  parameter int PHY_BURSTLEN  = 4,
  parameter int MEM_ADDR_BITS = 10,
  parameter int RD_LATENCY    = 4,
  parameter int CMDQ_DEPTH    = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    dfi_cke_i,
  input  logic                    dfi_cs_ni,
  input  logic                    dfi_ras_ni,
  input  logic                    dfi_cas_ni,
  input  logic                    dfi_we_ni,
  input  logic [2:0]              dfi_bank_i,
  input  logic [DDR_ROW_BITS-1:0] dfi_addr_i,
  input  logic                    dfi_wren_i,
  input  logic [DFI_DM_WIDTH-1:0] dfi_mask_i,
  input  logic [DFI_DQ_WIDTH-1:0] dfi_data_i,
  input  logic                    dfi_rden_i,
  output logic                    dfi_rvld_o,
  output logic                    dfi_last_o,
  output logic [DFI_DQ_WIDTH-1:0] dfi_data_o,
  output logic                    err_o,
  output logic [2:0]              err_code_o
);
  localparam int AW = MEM_ADDR_BITS;
  localparam int BW = $clog2(PHY_BURSTLEN);
  localparam int BL = DFI_DQ_WIDTH / DFI_DM_WIDTH;
  // Reset asserts asynchronously but releases two clocks after reset_n rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  assign rst_n = rst_sync_q[1];
  cmd_e cmd;
  logic cmd_v, is_act, is_pre, is_rd, is_wr;
  assign cmd    = cmd_e'({dfi_ras_ni, dfi_cas_ni, dfi_we_ni});
  assign cmd_v  = dfi_cke_i & ~dfi_cs_ni;
  assign is_act = cmd_v && cmd == CMD_ACT;
  assign is_pre = cmd_v && cmd == CMD_PRE;
  assign is_rd  = cmd_v && cmd == CMD_RD;
  assign is_wr  = cmd_v && cmd == CMD_WR;
  logic [DDR_ROW_BITS-1:0] row_q [NUM_BANKS];
  logic [AW-1:0] base;
  // Storage depth is smaller than the device: upper bank/row bits alias.
  assign base = AW'({dfi_bank_i, row_q[dfi_bank_i], dfi_addr_i[DDR_COL_BITS-1:BW], {BW{1'b0}}});
`ifdef DDR3_DFI_RESP_CHECK_EN
  localparam int WQW = AW + 4;
`else
  localparam int WQW = AW;
`endif
  logic [WQW-1:0] wq_din, wq_head;
  logic [AW-1:0]  rq_head;
  logic rq_push, rq_pop, rq_full, rq_empty, wq_push, wq_pop, wq_full, wq_empty;
  logic rd_hit, wr_hit;
  logic [BW-1:0] rbeat_q, wbeat_q;
`ifdef DDR3_DFI_RESP_CHECK_EN
  assign wq_din = {dfi_addr_i[10], dfi_bank_i, base};
`else
  assign wq_din = base;
`endif
  assign rd_hit  = dfi_rden_i & ~rq_empty;
  assign wr_hit  = dfi_wren_i & ~wq_empty;
  assign rq_pop  = rd_hit && rbeat_q == BW'(PHY_BURSTLEN - 1);
  assign wq_pop  = wr_hit && wbeat_q == BW'(PHY_BURSTLEN - 1);
  assign rq_push = is_rd && (!rq_full || rq_pop);
  assign wq_push = is_wr && (!wq_full || wq_pop);
  dfi_addr_fifo #(.W(AW), .DEPTH(CMDQ_DEPTH)) u_rq (
    .clk_i(clock), .rst_ni(rst_n), .push_i(rq_push), .pop_i(rq_pop),
    .data_i(base), .data_o(rq_head), .full_o(rq_full), .empty_o(rq_empty)
  );
  dfi_addr_fifo #(.W(WQW), .DEPTH(CMDQ_DEPTH)) u_wq (
    .clk_i(clock), .rst_ni(rst_n), .push_i(wq_push), .pop_i(wq_pop),
    .data_i(wq_din), .data_o(wq_head), .full_o(wq_full), .empty_o(wq_empty)
  );
  logic [DFI_DQ_WIDTH-1:0] mem_q [2**AW];
  logic [AW-1:0] waddr, raddr;
  assign waddr = wq_head[AW-1:0] + AW'(wbeat_q);
  assign raddr = rq_head + AW'(rbeat_q);
  // Not reset; a same-cycle read of the written word returns the old value.
  always_ff @(posedge clock)
    if (wr_hit)
      for (int b = 0; b < DFI_DM_WIDTH; b++)
        if (!dfi_mask_i[b]) mem_q[waddr][b*BL +: BL] <= dfi_data_i[b*BL +: BL];
  logic [RD_LATENCY-1:0]   vld_q, last_q;
  logic [DFI_DQ_WIDTH-1:0] dat_q [RD_LATENCY];
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      vld_q  <= '0;
      last_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0]  <= dfi_rden_i;
      last_q[0] <= rq_pop;
      dat_q[0]  <= rd_hit ? mem_q[raddr] : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        last_q[i] <= last_q[i-1];
        dat_q[i]  <= dat_q[i-1];
      end
    end
  assign dfi_rvld_o = vld_q[RD_LATENCY-1];
  assign dfi_last_o = last_q[RD_LATENCY-1];
  assign dfi_data_o = dat_q[RD_LATENCY-1];
  logic [7:1] ev;
  assign ev[3] = (is_rd && rq_full && !rq_pop) || (is_wr && wq_full && !wq_pop);
  assign ev[4] = dfi_rden_i && rq_empty;
  assign ev[5] = dfi_wren_i && wq_empty;
`ifdef DDR3_DFI_RESP_CHECK_EN
  logic [NUM_BANKS-1:0] open_q, open_d;
  assign ev[1] = is_act && open_q[dfi_bank_i];
  assign ev[2] = (is_rd || is_wr) && !open_q[dfi_bank_i];
  assign ev[6] = cmd_v && cmd == CMD_REF && |open_q;
  assign ev[7] = cmd_v && cmd == CMD_MRS;
  // Auto-precharge close at write pop, then PRE, then ACT wins.
  always_comb begin
    open_d = open_q;
    if (wq_pop && wq_head[AW+3]) open_d[wq_head[AW+2:AW]] = 1'b0;
    if (is_pre) open_d = dfi_addr_i[10] ? '0 : open_d & ~(NUM_BANKS'(1) << dfi_bank_i);
    if (is_act) open_d[dfi_bank_i] = 1'b1;
  end
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) open_q <= '0;
    else        open_q <= open_d;
`else
  assign ev[1] = 1'b0;
  assign ev[2] = 1'b0;
  assign ev[6] = 1'b0;
  assign ev[7] = 1'b0;
`endif
  logic [2:0] err_d;
  always_comb begin
    err_d = ERR_NONE;
    for (int i = 7; i >= 1; i--) if (ev[i]) err_d = 3'(i);
  end
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      rbeat_q    <= '0;
      wbeat_q    <= '0;
      err_o      <= 1'b0;
      err_code_o <= ERR_NONE;
      for (int i = 0; i < NUM_BANKS; i++) row_q[i] <= '0;
    end else begin
      if (rd_hit) rbeat_q <= rq_pop ? '0 : rbeat_q + BW'(1);
      if (wr_hit) wbeat_q <= wq_pop ? '0 : wbeat_q + BW'(1);
      if (is_act) row_q[dfi_bank_i] <= dfi_addr_i;
      if (!err_o && |ev) begin
        err_o      <= 1'b1;
        err_code_o <= err_d;
      end
    end
endmodule

// File: doc/ddr3_dfi_responder.md
Name: ddr3_dfi_responder

Overview:
Synthesizable DFI-side responder that stands in for the DDR3 PHY and SDRAM behind the memory controller's DFI port. It decodes DFI commands and tracks the open row for each bank. WRITE bursts land in internal block RAM; READ data comes back on dfi_rvld/dfi_last/dfi_data after a fixed latency. Uses: controller simulation and FPGA loopback tests without a real PHY. It also flags DFI protocol violations.

Parameters:
DDR_ROW_BITS, 15, row-address width (dfi_addr width)
DDR_COL_BITS, 10, column-address width
DFI_DQ_WIDTH, 32, DFI data width per clock
DFI_DM_WIDTH, 4, DFI mask width (one bit per byte)
PHY_BURSTLEN, 4, DFI words per READ/WRITE burst
MEM_ADDR_BITS, 10, log2 of internal storage depth in DFI words
RD_LATENCY, 4, clocks from dfi_rden_i sample to dfi_rvld_o (min 1)
CMDQ_DEPTH, 4, pending READ and pending WRITE burst-address queue depth (power of 2)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
dfi_cke_i  in  1  clock enable; commands are ignored when low
dfi_cs_ni  in  1  chip select, active low
dfi_ras_ni, dfi_cas_ni, dfi_we_ni  in  1 each  command encoding
dfi_bank_i  in  3  bank address
dfi_addr_i  in  DDR_ROW_BITS  row/column address; bit 10 = auto-precharge / precharge-all
dfi_wren_i  in  1  write-data beat valid
dfi_mask_i  in  DFI_DM_WIDTH  byte mask; 1 = byte not written
dfi_data_i  in  DFI_DQ_WIDTH  write data
dfi_rden_i  in  1  read-data beat request
dfi_rvld_o  out  1  read data valid
dfi_last_o  out  1  final beat of a read burst
dfi_data_o  out  DFI_DQ_WIDTH  read data
err_o  out  1  sticky protocol-error flag
err_code_o  out  3  code of the first error seen

Behaviour:
- Reset (async assert, sync deassert internally): dfi_rvld_o=0, dfi_last_o=0, dfi_data_o=0, err_o=0, err_code_o=0.
  - Also cleared: queues, latency pipe, bank open flags, row registers. Storage RAM contents are not cleared.
- Command decode: a command is valid only when cke=1 and cs_n=0. {ras,cas,we}:
  - 000 MRS: ignored.
  - 001 REF: ignored.
  - 010 PRE: close dfi_bank_i; addr[10]=1 closes all banks.
  - 011 ACT: open the bank and latch the row.
  - 100 WR, 101 RD: described below.
  - 110 ZQCL: ignored.
  - 111 NOP.
- Word address = low MEM_ADDR_BITS of {bank, row[bank], col[CSB:log2(PHY_BURSTLEN)], beat}. Aliasing beyond this depth is by design.
- WR: push the burst base address into the write queue.
  - Each dfi_wren_i cycle writes one beat at head+beat counter, per-byte under mask.
  - After PHY_BURSTLEN beats, pop the queue. If addr[10]=1, close the bank at pop.
- RD: push the burst base address into the read queue.
  - Each dfi_rden_i cycle reads head+beat from RAM into a RD_LATENCY-deep valid/last/data pipe.
  - Pop on the PHY_BURSTLEN-th beat. dfi_last_o is asserted with that beat.
  - Data emerges exactly RD_LATENCY clocks after the rden sample. Back-to-back bursts stream without bubbles.
- Same-cycle RD/WR command and data beat: the push and pop both take effect, so queue count is unchanged.
- Queue full at push: command dropped, error 3.
- Beat with empty queue:
  - rden: rvld still asserted, data 0, last=0, error 4.
  - wren: data discarded, error 5.
- Read-after-write to the same word in the same cycle returns the old data (RAM read-first).

Optional Feature:
DDR3_DFI_RESP_CHECK_EN defined: bank-state checker compiled in. Error codes:
- 1: ACT to an already-open bank.
- 2: RD or WR to a closed bank.
- 6: REF while any bank is open.
- 7: unsupported command while cke=1 (ZQCL excluded).
Undefined: open-flag logic removed and codes 1, 2, 6, 7 never raised. Codes 3/4/5 remain. Row latching is always present.

Decomposition:
- Shared package ddr3_dfi_pkg: command encodings (CMD_MRS..CMD_NOP), error-code localparams, bank count (8).
- One sub-module, dfi_addr_fifo: a CMDQ_DEPTH-entry address FIFO with full/empty, instantiated twice (read and write queues).

Test Plan:
- ACT b2 row 0x15, WR col 0x010, 4 wren beats 0xA0..0xA3 mask 0, then RD col 0x010 + 4 rden -> rvld 4 beats 0xA0..0xA3, 4 clocks after each rden; last on beat 4; err_o=0.
- WR with mask 4'b0011 data 0xFFFFFFFF over a word holding 0x12345678 -> readback 0xFFFF5678.
- 5 RD commands with no rden, CMDQ_DEPTH=4 -> err_o=1, err_code_o=3; the first 4 bursts still return correctly.
- rden with empty read queue -> rvld=1, data 0, last=0; err_code_o=4.
- (CHECK_EN) RD to a closed bank 5 -> err_code_o=2. A later error does not change the code.
- reset_n low mid-burst during the 2nd of 4 rden beats -> outputs 0 within the same cycle; after release, queues are empty and earlier-written data still reads back correctly.
